// File: rtl/gru_pkg.sv
// gru_pkg: shared frame geometry, region offsets and state encodings for the GRU loader
package gru_pkg;
  localparam int DEF_SEQ_LENGTH = 4;
  localparam int DEF_INPUT_FEATURES = 3;
  localparam int DEF_GRU_UNITS = 3;
  localparam int OFS_X = 0;
  localparam int OFS_WR = OFS_X + DEF_SEQ_LENGTH * DEF_INPUT_FEATURES;
  localparam int OFS_UR = OFS_WR + DEF_INPUT_FEATURES;
  localparam int OFS_BR = OFS_UR + DEF_GRU_UNITS;
  localparam int OFS_WZ = OFS_BR + 1;
  localparam int OFS_UZ = OFS_WZ + DEF_INPUT_FEATURES;
  localparam int OFS_BZ = OFS_UZ + DEF_GRU_UNITS;
  localparam int OFS_WH = OFS_BZ + 1;
  localparam int OFS_UH = OFS_WH + DEF_INPUT_FEATURES;
  localparam int OFS_BH = OFS_UH + DEF_GRU_UNITS;
  function automatic int total_words(int seq, int feat, int units);
    return seq * feat + 3 * (feat + units + 1);
  endfunction
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic {LD_LOAD, LD_DONE} ld_state_t;
endpackage

// File: rtl/uart_word_loader_if.sv
// uart_word_loader_if: UART line, clear and word-write bus of the loader
interface uart_word_loader_if #(parameter int DW = 32, parameter int AW = 6);
  logic uart_rx;
  logic clear;
  logic wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic load_done;
  logic frame_err;
  logic timeout;
  modport master(input uart_rx, clear, output wr_en, wr_addr, wr_data, load_done, frame_err, timeout);
  modport slave(output uart_rx, clear, input wr_en, wr_addr, wr_data, load_done, frame_err, timeout);
endinterface

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART receiver with 2-FF synchroniser, byte_valid/stop_err pulses
module uart_rx_byte
  import gru_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       stop_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  logic rx_m, rx_s;
  rx_state_t st, nxt;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  logic half_tick, full_tick;
  assign half_tick = cnt == HALF;
  assign full_tick = cnt == FULL;
  // line synchroniser, idles high
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) {rx_s, rx_m} <= 2'b11;
    else {rx_s, rx_m} <= {rx_m, rx};
  // receiver state register
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) st <= RX_IDLE;
    else st <= nxt;
  // receiver next state: mid-start check rejects glitches, then whole-bit sampling
  always_comb begin
    nxt = st;
    unique case (st)
      RX_IDLE:  nxt = rx_s ? RX_IDLE : RX_START;
      RX_START: nxt = half_tick ? (rx_s ? RX_IDLE : RX_DATA) : RX_START;
      RX_DATA:  nxt = (full_tick && bit_idx == 3'd7) ? RX_STOP : RX_DATA;
      RX_STOP:  nxt = full_tick ? RX_IDLE : RX_STOP;
    endcase
  end
  // bit timer restarts on every state change and bit boundary; data shifts in LSB first
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      cnt <= '0;
      bit_idx <= '0;
      byte_data <= '0;
    end else begin
      cnt <= (st == RX_IDLE || st != nxt || full_tick) ? '0 : cnt + 1'b1;
      if (st == RX_DATA && full_tick) begin
        bit_idx <= bit_idx + 1'b1;
        byte_data <= {rx_s, byte_data[7:1]};
      end
    end
  // stop-bit verdict
  always_comb begin
    byte_valid = st == RX_STOP && full_tick && rx_s;
    stop_err = st == RX_STOP && full_tick && !rx_s;
  end
endmodule

// File: rtl/uart_word_loader.sv
// uart_word_loader: packs UART bytes little-endian into words and writes the GRU frame; UART_WORD_LOADER_TIMEOUT_EN adds an inter-byte timeout
module uart_word_loader
  import gru_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10417,
  parameter int DATA_WIDTH = 32,
  parameter int GRU_UNITS = DEF_GRU_UNITS,
  parameter int INPUT_FEATURES = DEF_INPUT_FEATURES,
  parameter int SEQ_LENGTH = DEF_SEQ_LENGTH
`ifdef UART_WORD_LOADER_TIMEOUT_EN
  , parameter int TIMEOUT_CLKS = 16 * CLKS_PER_BIT
`endif
) (
  input logic clk,
  input logic rstn,
  uart_word_loader_if.master bus
);
  localparam int TW = total_words(SEQ_LENGTH, INPUT_FEATURES, GRU_UNITS);
  localparam int AW = $clog2(TW);
  localparam int NB = DATA_WIDTH / 8;
  localparam int BW = NB > 1 ? $clog2(NB) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(TW - 1);
  logic byte_valid, stop_err;
  logic [7:0] byte_data;
  ld_state_t ld_st, ld_nxt;
  logic [AW-1:0] addr;
  logic [BW-1:0] bidx;
  logic [DATA_WIDTH-1:0] wbuf, word_nxt;
  logic accept, last, expire;
  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk(clk),
    .rstn(rstn),
    .rx(bus.uart_rx),
    .byte_valid(byte_valid),
    .byte_data(byte_data),
    .stop_err(stop_err)
  );
  assign accept = byte_valid && ld_st == LD_LOAD && !bus.clear;
  assign last = bidx == BW'(NB - 1);
`ifdef UART_WORD_LOADER_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CLKS + 1);
  logic [TCW-1:0] to_cnt;
  assign expire = bidx != '0 && to_cnt == TCW'(TIMEOUT_CLKS - 1) && !byte_valid;
  // inter-byte timer runs only while a word is partially assembled
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) to_cnt <= '0;
    else to_cnt <= (bus.clear || byte_valid || bidx == '0 || expire) ? '0 : to_cnt + 1'b1;
`else
  assign expire = 1'b0;
`endif
  // loader state register
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) ld_st <= LD_LOAD;
    else ld_st <= ld_nxt;
  // loader next state: clear re-arms, the final word write finishes the frame
  always_comb ld_nxt = bus.clear ? LD_LOAD : (accept && last && addr == LAST_ADDR) ? LD_DONE : ld_st;
  // loader outputs
  always_comb bus.load_done = ld_st == LD_DONE;
  // drop the incoming byte into its lane of the word under assembly
  always_comb begin
    word_nxt = wbuf;
    word_nxt[{bidx, 3'b000} +: 8] = byte_data;
  end
  // packer, address counter and write port; address saturates so it never wraps
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      addr <= '0;
      bidx <= '0;
      wbuf <= '0;
      bus.wr_en <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      bus.frame_err <= 1'b0;
      bus.timeout <= 1'b0;
    end else if (bus.clear) begin
      addr <= '0;
      bidx <= '0;
      bus.wr_en <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.timeout <= 1'b0;
    end else begin
      bus.wr_en <= accept && last;
      bus.timeout <= expire;
      bus.frame_err <= bus.frame_err | stop_err;
      if (accept) begin
        wbuf <= word_nxt;
        bidx <= last ? '0 : bidx + 1'b1;
      end else if (expire) bidx <= '0;
      if (accept && last) begin
        bus.wr_addr <= addr;
        bus.wr_data <= word_nxt;
        addr <= addr == LAST_ADDR ? addr : addr + 1'b1;
      end
    end
endmodule

// File: tb/tb_uart_word_loader.sv
// tb_uart_word_loader: scoreboard bench for uart_word_loader
module tb_uart_word_loader;
  import gru_pkg::*;
  localparam int CPB = 16;
  localparam int DW = 32;
  localparam int TW = total_words(DEF_SEQ_LENGTH, DEF_INPUT_FEATURES, DEF_GRU_UNITS);
  localparam int AW = $clog2(TW);
  localparam int TOC = 16 * CPB;
  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  wr_t q[$];
  wr_t e;
  int nchk = 0, nfail = 0, nwr = 0, nbv = 0, nto = 0, cyc = 0, bv_cyc = -10;
  logic [DW-1:0] cap[TW];
  logic [31:0] xf[12] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                          32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
                          32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000};
  logic [31:0] wu[3] = '{32'h40400000, 32'h40000000, 32'h3F800000};
  int ofs[9] = '{OFS_WR, OFS_UR, OFS_BR, OFS_WZ, OFS_UZ, OFS_BZ, OFS_WH, OFS_UH, OFS_BH};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_word_loader_if #(.DW(DW), .AW(AW)) bus ();
  uart_word_loader #(
    .CLKS_PER_BIT(CPB), .DATA_WIDTH(DW), .GRU_UNITS(3), .INPUT_FEATURES(3), .SEQ_LENGTH(4)
  ) dut (.clk(clk), .rstn(rstn), .bus(bus));

  function automatic logic [31:0] frame_word(int a);
    int base = 0;
    if (a < OFS_WR) return xf[a];
    if (a == OFS_BR || a == OFS_BZ || a == OFS_BH) return 32'h0;
    for (int i = 0; i < 9; i++) if (ofs[i] <= a) base = ofs[i];
    return wu[a - base];
  endfunction

  // write monitor: scoreboard pop, 1-cycle latency, load_done alignment
  always @(negedge clk) if (rstn) begin
    if (dut.byte_valid) begin
      nbv++;
      bv_cyc = cyc;
    end
    if (bus.timeout) nto++;
    if (bus.wr_en) begin
      nwr++;
      if (int'(bus.wr_addr) < TW) cap[bus.wr_addr] = bus.wr_data;
      nchk++;
      if (q.size() == 0) begin
        nfail++;
        $display("FAIL unexpected_write: got addr %0d data %h, expected no write", bus.wr_addr, bus.wr_data);
      end else begin
        e = q.pop_front();
        if ({bus.wr_addr, bus.wr_data} !== e) begin
          nfail++;
          $display("FAIL write: got addr %0d data %h, expected addr %0d data %h", bus.wr_addr, bus.wr_data, e.a, e.d);
        end
      end
      nchk++;
      if (cyc - bv_cyc != 1) begin
        nfail++;
        $display("FAIL write_latency: got %0d cycles after byte_valid, expected 1", cyc - bv_cyc);
      end
      nchk++;
      if (bus.load_done !== (int'(bus.wr_addr) == TW - 1)) begin
        nfail++;
        $display("FAIL load_done_at_write: addr %0d got load_done %b", bus.wr_addr, bus.load_done);
      end
    end
  end

  initial begin
    #800us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk) bus.uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    bus.uart_rx = stop;
    repeat (CPB) @(negedge clk);
    bus.uart_rx = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_word(input logic [DW-1:0] w);
    for (int k = 0; k < DW / 8; k++) send_byte(w[8*k +: 8], 1'b1);
  endtask

  task automatic pulse_clear();
    @(negedge clk) bus.clear = 1'b1;
    @(negedge clk) bus.clear = 1'b0;
  endtask

  task automatic test_reset();
    bus.uart_rx = 1'b1;
    bus.clear = 1'b0;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    nchk += 6;
    if (bus.wr_en !== 1'b0) begin nfail++; $display("FAIL reset_wr_en: got %b, expected 0", bus.wr_en); end
    if (bus.wr_addr !== '0) begin nfail++; $display("FAIL reset_wr_addr: got %0d, expected 0", bus.wr_addr); end
    if (bus.wr_data !== '0) begin nfail++; $display("FAIL reset_wr_data: got %h, expected 0", bus.wr_data); end
    if (bus.load_done !== 1'b0) begin nfail++; $display("FAIL reset_load_done: got %b, expected 0", bus.load_done); end
    if (bus.frame_err !== 1'b0) begin nfail++; $display("FAIL reset_frame_err: got %b, expected 0", bus.frame_err); end
    if (bus.timeout !== 1'b0) begin nfail++; $display("FAIL reset_timeout: got %b, expected 0", bus.timeout); end
    rstn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_word();
    int n0 = nwr;
    q.push_back('{a: AW'(0), d: 32'h3F800000});
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h80, 1'b1);
    send_byte(8'h3F, 1'b1);
    repeat (4) @(negedge clk);
    nchk += 2;
    if (q.size() != 0) begin nfail++; $display("FAIL single_pending: got %0d, expected 0", q.size()); q.delete(); end
    if (nwr - n0 != 1) begin nfail++; $display("FAIL single_count: got %0d writes, expected 1", nwr - n0); end
  endtask

  task automatic test_full_frame();
    int n0;
    pulse_clear();
    n0 = nwr;
    for (int a = 0; a < TW; a++) begin
      q.push_back('{a: AW'(a), d: frame_word(a)});
      send_word(frame_word(a));
    end
    repeat (4) @(negedge clk);
    nchk += 4;
    if (q.size() != 0) begin nfail++; $display("FAIL frame_pending: got %0d, expected 0", q.size()); q.delete(); end
    if (nwr - n0 != TW) begin nfail++; $display("FAIL frame_count: got %0d writes, expected %0d", nwr - n0, TW); end
    if (cap[OFS_BR] !== 32'h0) begin nfail++; $display("FAIL frame_addr18: got %h, expected 0", cap[OFS_BR]); end
    if (bus.load_done !== 1'b1) begin nfail++; $display("FAIL frame_done: got %b, expected 1", bus.load_done); end
  endtask

  task automatic test_after_done();
    int n0 = nwr;
    send_word(32'hDEADBEEF);
    repeat (4) @(negedge clk);
    nchk += 2;
    if (nwr != n0) begin nfail++; $display("FAIL done_drop: got %0d writes, expected 0", nwr - n0); end
    if (bus.load_done !== 1'b1) begin nfail++; $display("FAIL done_hold: got %b, expected 1", bus.load_done); end
    pulse_clear();
    nchk++;
    if (bus.load_done !== 1'b0) begin nfail++; $display("FAIL clear_done: got %b, expected 0", bus.load_done); end
    q.push_back('{a: AW'(0), d: 32'h12345678});
    send_word(32'h12345678);
    repeat (4) @(negedge clk);
    nchk++;
    if (q.size() != 0) begin nfail++; $display("FAIL clear_rewrite_pending: got %0d, expected 0", q.size()); q.delete(); end
  endtask

  task automatic test_errors();
    int b0 = nbv;
    int n0 = nwr;
    @(negedge clk) bus.uart_rx = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    bus.uart_rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    nchk += 2;
    if (nbv != b0) begin nfail++; $display("FAIL glitch_byte: got %0d byte_valid, expected 0", nbv - b0); end
    if (bus.frame_err !== 1'b0) begin nfail++; $display("FAIL glitch_err: got %b, expected 0", bus.frame_err); end
    send_byte(8'h55, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    nchk += 3;
    if (bus.frame_err !== 1'b1) begin nfail++; $display("FAIL stop_err: got %b, expected 1", bus.frame_err); end
    if (nbv != b0) begin nfail++; $display("FAIL stop_drop: got %0d byte_valid, expected 0", nbv - b0); end
    if (nwr != n0) begin nfail++; $display("FAIL stop_write: got %0d writes, expected 0", nwr - n0); end
    q.push_back('{a: AW'(1), d: 32'hA5C3_0F01});
    send_word(32'hA5C3_0F01);
    repeat (4) @(negedge clk);
    nchk += 2;
    if (q.size() != 0) begin nfail++; $display("FAIL err_next_pending: got %0d, expected 0", q.size()); q.delete(); end
    if (bus.frame_err !== 1'b1) begin nfail++; $display("FAIL err_sticky: got %b, expected 1", bus.frame_err); end
  endtask

  task automatic test_reset_mid();
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    @(negedge clk) rstn = 1'b0;
    #1;
    nchk += 5;
    if (bus.wr_en !== 1'b0) begin nfail++; $display("FAIL midrst_wr_en: got %b, expected 0", bus.wr_en); end
    if (bus.wr_addr !== '0) begin nfail++; $display("FAIL midrst_wr_addr: got %0d, expected 0", bus.wr_addr); end
    if (bus.wr_data !== '0) begin nfail++; $display("FAIL midrst_wr_data: got %h, expected 0", bus.wr_data); end
    if (bus.load_done !== 1'b0) begin nfail++; $display("FAIL midrst_done: got %b, expected 0", bus.load_done); end
    if (bus.frame_err !== 1'b0) begin nfail++; $display("FAIL midrst_frame_err: got %b, expected 0", bus.frame_err); end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    q.push_back('{a: AW'(0), d: 32'h0BADF00D});
    send_word(32'h0BADF00D);
    repeat (4) @(negedge clk);
    nchk++;
    if (q.size() != 0) begin nfail++; $display("FAIL midrst_next_pending: got %0d, expected 0", q.size()); q.delete(); end
  endtask

  task automatic test_timeout();
    int n0 = nwr;
    int t0 = nto;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    repeat (TOC + 2 * CPB) @(negedge clk);
    nchk += 2;
    if (nwr != n0) begin nfail++; $display("FAIL idle_write: got %0d writes, expected 0", nwr - n0); end
`ifdef UART_WORD_LOADER_TIMEOUT_EN
    if (nto - t0 != 1) begin nfail++; $display("FAIL timeout_pulse: got %0d pulses, expected 1", nto - t0); end
    q.push_back('{a: AW'(1), d: 32'h44332211});
    send_word(32'h44332211);
`else
    if (nto != t0) begin nfail++; $display("FAIL timeout_tied: got %0d pulses, expected 0", nto - t0); end
    q.push_back('{a: AW'(1), d: 32'h44332211});
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
`endif
    repeat (4) @(negedge clk);
    nchk++;
    if (q.size() != 0) begin nfail++; $display("FAIL idle_next_pending: got %0d, expected 0", q.size()); q.delete(); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_full_frame();
    test_after_done();
    test_errors();
    test_reset_mid();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
